// File: rtl/bit_pack_pkg.sv
// ---------------------------------------------------------------------------
// bit_pack_pkg
// Shared definitions for the bit_pack block and its slice counter:
//   - ARCHITECTURE selector strings
//   - legal upper limits for slice width and slices per word
//   - count_width(): number of bits needed to count NUM_SLICES slots
// ---------------------------------------------------------------------------
package bit_pack_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  localparam int MAX_INPUT_DATA_WIDTH = 64;
  localparam int MAX_NUM_SLICES       = 64;

  // Width of a counter holding 0..num_slices-1; never narrower than 1 bit.
  function automatic int count_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/bit_pack_slice_counter.sv
// ---------------------------------------------------------------------------
// slice_counter
// Slot counter for bit_pack, counting 0..NUM_SLICES-1 and wrapping to 0.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (count -> 0)
//   inc   in   count one slice this cycle
//   clr   in   restart the word; applied before inc, so clr+inc gives 1
//   count out  current slot index
// ---------------------------------------------------------------------------
module slice_counter
  import bit_pack_pkg::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int COUNT_W    = count_width(NUM_SLICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] base;
  logic [COUNT_W-1:0] count_next;

  always_comb begin
    base       = clr ? '0 : count_reg;
    count_next = base;
    if (inc) begin
      count_next = (base == COUNT_W'(NUM_SLICES - 1)) ? '0 : base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/bit_pack.sv
// ---------------------------------------------------------------------------
// bit_pack
// Packs NUM_SLICES consecutive INPUT_DATA_WIDTH-bit slices into one word.
// The first slice of a word goes to the MSBs (MSB_FIRST=1) or LSBs (0).
// sync_in forces the current slice (if any) into slot 0; a sync arriving
// mid-word discards the partial word and pulses sync_err.
//
// Optional feature macro: BIT_PACK_FLUSH_EN
//   Adds flush_in: emits a partially filled word (empty slots zero).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   data_in    in   [W-1:0] slice
//   en_in      in   data_in valid
//   sync_in    in   start-of-word marker
//   data_out   out  [W*N-1:0] packed word, registered, held between loads
//   valid_out  out  one-cycle pulse when data_out is new
//   sync_err   out  one-cycle pulse when sync_in arrived mid-word
//   flush_in   in   (BIT_PACK_FLUSH_EN only) emit partial word
// ---------------------------------------------------------------------------
module bit_pack
  import bit_pack_pkg::*;
#(
  parameter string BLOCK_NAME       = "bit_pack",
  parameter int    X                = 0,
  parameter int    Y                = 0,
  parameter int    DX               = 0,
  parameter int    DY               = 0,
  parameter string ARCHITECTURE     = "BEHAVIORAL",
  parameter int    INPUT_DATA_WIDTH = 8,
  parameter int    NUM_SLICES       = 4,
  parameter int    MSB_FIRST        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INPUT_DATA_WIDTH-1:0]            data_in,
  input  logic                                   en_in,
  input  logic                                   sync_in,
  output logic [INPUT_DATA_WIDTH*NUM_SLICES-1:0] data_out,
  output logic                                   valid_out,
  output logic                                   sync_err
`ifdef BIT_PACK_FLUSH_EN
  ,
  input  logic                                   flush_in
`endif
);

  localparam int W      = INPUT_DATA_WIDTH;
  localparam int N      = NUM_SLICES;
  localparam int WORD_W = W * N;
  localparam int CW     = count_width(N);

  // Elaboration-time parameter checks.
  if (W < 1 || W > MAX_INPUT_DATA_WIDTH) begin : g_bad_width
    $error("bit_pack: INPUT_DATA_WIDTH out of range 1..64");
  end
  if (N < 2 || N > MAX_NUM_SLICES) begin : g_bad_slices
    $error("bit_pack: NUM_SLICES out of range 2..64");
  end
  if (X < 0 || Y < 0 || DX < 0 || DY < 0 || BLOCK_NAME == "") begin : g_bad_diagram
    $error("bit_pack: diagram placement parameters are invalid");
  end

  if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral

    logic [CW-1:0]     count;
    logic [CW-1:0]     slot;
    logic              flush_fire;
    logic              last_slot;
    logic              load;
    logic [WORD_W-1:0] partial_reg;
    logic [WORD_W-1:0] partial_base;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] data_out_reg;
    logic              valid_out_reg;
    logic              sync_err_reg;

`ifdef BIT_PACK_FLUSH_EN
    // Flush only if a partial word exists after this cycle's slice; sync
    // wins, and a flush on the final slot is just the normal full load.
    assign flush_fire = flush_in & ~sync_in &
                        (en_in ? (count != CW'(N - 1)) : (count != '0));
`else
    assign flush_fire = 1'b0;
`endif

    // A sync restarts the word, so the incoming slice lands in slot 0.
    assign slot         = sync_in ? '0 : count;
    assign partial_base = sync_in ? '0 : partial_reg;
    assign last_slot    = en_in & (slot == CW'(N - 1));
    assign load         = last_slot | flush_fire;

    // Merge the accepted slice into its slot; other slots keep prior content.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      localparam int LO = (MSB_FIRST != 0) ? W * (N - 1 - gi) : W * gi;
      assign merged[LO +: W] = (en_in && slot == CW'(gi)) ? data_in
                                                          : partial_base[LO +: W];
    end

    slice_counter #(
      .NUM_SLICES (N),
      .COUNT_W    (CW)
    ) u_slice_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (en_in & ~flush_fire),
      .clr   (sync_in | flush_fire),
      .count (count)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        partial_reg   <= '0;
        data_out_reg  <= '0;
        valid_out_reg <= 1'b0;
        sync_err_reg  <= 1'b0;
      end else begin
        valid_out_reg <= load;
        sync_err_reg  <= sync_in & (count != '0);
        partial_reg   <= load ? '0 : merged;
        if (load) begin
          data_out_reg <= merged;
        end
      end
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign sync_err  = sync_err_reg;

  end else begin : g_device_arch

    // VIRTEX5 and VIRTEX6 selections hold all outputs idle.
    if (ARCHITECTURE != ARCH_VIRTEX5 && ARCHITECTURE != ARCH_VIRTEX6) begin : g_bad_arch
      $error("bit_pack: unknown ARCHITECTURE");
    end
    assign data_out  = '0;
    assign valid_out = 1'b0;
    assign sync_err  = 1'b0;

  end

endmodule

// File: doc/bit_pack.md
BIT_PACK -- requirements
Module: bit_pack

Interface
REQ-001 Parameter BLOCK_NAME, "bit_pack", hierarchical block name (diagram only).
REQ-002 Parameters X, Y, DX, DY, 0, diagram position and size (no functional effect).
REQ-003 Parameter ARCHITECTURE, "BEHAVIORAL", implementation select; only BEHAVIORAL is implemented; VIRTEX5 and VIRTEX6 are empty placeholders.
REQ-004 Parameter INPUT_DATA_WIDTH, 8, width of each incoming slice; legal range 1..64.
REQ-005 Parameter NUM_SLICES, 4, slices per packed word; legal range 2..64.
REQ-006 Parameter MSB_FIRST, 1: 1 = first slice lands in the MSBs; 0 = first slice lands in the LSBs.
REQ-007 Port clk  input  1  sole clock; all logic is on its rising edge.
REQ-008 Port rst  input  1  synchronous, active-high reset.
REQ-009 Port data_in  input  INPUT_DATA_WIDTH  slice, typically from an upstream slice stage.
REQ-010 Port en_in  input  1  data_in is valid this cycle.
REQ-011 Port sync_in  input  1  start-of-word marker.
REQ-012 Port data_out  output  INPUT_DATA_WIDTH*NUM_SLICES  packed word, registered.
REQ-013 Port valid_out  output  1  one-cycle pulse; data_out is new this cycle.
REQ-014 Port sync_err  output  1  one-cycle pulse; sync_in arrived mid-word.

Function
REQ-015 The block is always ready and has no backpressure; a slice is accepted on every cycle with en_in=1.
REQ-016 A slice counter, range 0..NUM_SLICES-1, selects the slot for the accepted slice, then increments.
- Slot k with MSB_FIRST=1 occupies bits [W*(N-k)-1 : W*(N-1-k)].
- Slot k with MSB_FIRST=0 occupies bits [W*(k+1)-1 : W*k].
- Here W = INPUT_DATA_WIDTH and N = NUM_SLICES.
REQ-017 When the slice in slot N-1 is accepted:
- the counter wraps to 0;
- the complete word loads into data_out;
- valid_out=1 on the next cycle (latency 1 cycle after the last slice).
REQ-018 data_out holds its value until the next load; valid_out is high for exactly one cycle per load.
REQ-019 sync_in=1 with en_in=1: the accepted slice is placed in slot 0 and the counter becomes 1; any partial word is discarded.
REQ-020 sync_in=1 with en_in=0: the counter becomes 0 and any partial word is discarded.
REQ-021 sync_in while the counter is nonzero pulses sync_err on the next cycle; sync_in with the counter at 0 produces no error.
REQ-022 If N=1 is forced at elaboration, elaboration fails.
REQ-023 Gaps in en_in do not affect slot assignment.

Reset
REQ-024 On rst=1 at a clock edge, all of the following are cleared, overriding all inputs that cycle:
- counter = 0;
- partial word = 0;
- data_out = 0;
- valid_out = 0;
- sync_err = 0.
REQ-025 Reset mid-word discards the partial word; no valid_out follows.
REQ-026 The first slice after reset goes to slot 0.

Configuration
REQ-027 Macro BIT_PACK_FLUSH_EN adds input port flush_in (1 bit).
- When flush_in=1 and the counter is nonzero (after accepting any same-cycle en_in slice), the partial word, with unfilled slots zero, loads into data_out.
- valid_out pulses on the next cycle, and the counter returns to 0.
- flush_in=1 with the counter at 0 and en_in=0 has no effect.
- flush_in coinciding with acceptance of slot N-1 produces exactly one valid_out.
- flush_in and sync_in together: sync_in takes priority.
REQ-028 Without BIT_PACK_FLUSH_EN, the flush_in port and flush logic do not exist; behaviour is otherwise identical.

Structure
REQ-029 Shared package bit_pack_pkg holds:
- the ARCHITECTURE string constants;
- the maximum width limits;
- a clog2-based function for the counter width.
REQ-030 The slice counter is a sub-module, slice_counter, with ports clk, rst, inc, clr and count, and wrap at NUM_SLICES.

Verification (W=8, N=4, MSB_FIRST=1 unless noted)
REQ-031 en_in for 4 cycles with sync on the first, data 0x11,0x22,0x33,0x44 -> one cycle later, data_out=0x11223344, valid_out=1 for one cycle.
REQ-032 Same stimulus with MSB_FIRST=0 -> data_out=0x44332211.
REQ-033 0x11,0x22, then sync_in with 0xAA, then 0xBB,0xCC,0xDD -> sync_err pulses once; data_out=0xAABBCCDD; no word containing 0x11.
REQ-034 Slices 0x01,0x02,0x03,0x04 with one idle cycle between each -> data_out=0x01020304; exactly one valid_out.
REQ-035 rst asserted after two slices, then 4 new slices 0x55..0x88 -> data_out=0x0 during reset, then 0x55667788.
REQ-036 With BIT_PACK_FLUSH_EN: 0x12,0x34 then flush_in -> data_out=0x12340000, valid_out=1; the next 4 slices pack from slot 0.
